// File: rtl/j1_io_arbiter_if.sv
// Bus bundle between the j1 I/O port, the auxiliary master and the peripheral bus.
interface j1_io_arbiter_if;
  // j1 CPU I/O port
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_addr;
  logic [15:0] io_dout;
  logic [15:0] io_din;
  // Peripheral bus
  logic        per_cs;
  logic        per_we;
  logic [15:0] per_addr;
  logic [15:0] per_wdata;
  logic [15:0] per_rdata;
  // Auxiliary master handshake
  logic        aux_req;
  logic        aux_we;
  logic [15:0] aux_addr;
  logic [15:0] aux_wdata;
  logic        aux_ack;
  logic [15:0] aux_rdata;

  // Arbiter side
  modport slave (
    input  io_rd, io_wr, io_addr, io_dout, per_rdata,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output io_din, per_cs, per_we, per_addr, per_wdata,
    output aux_ack, aux_rdata
  );

  // Environment side (CPU, aux master and peripherals)
  modport master (
    output io_rd, io_wr, io_addr, io_dout, per_rdata,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  io_din, per_cs, per_we, per_addr, per_wdata,
    input  aux_ack, aux_rdata
  );
endinterface

// File: rtl/j1_io_arbiter.sv
// Shares the peripheral I/O bus between the j1 CPU (absolute priority, zero
// latency) and an auxiliary req/ack master that only gets idle bus cycles.
// Also exposes a status word {wait_max, grant_cnt} at STAT_ADDR.
module j1_io_arbiter #(
  parameter logic [15:0] STAT_ADDR = 16'hFFFE,
  parameter int unsigned WAIT_W    = 8
) (
  input  logic           sys_clk_i,
  input  logic           sys_rst_i,
  j1_io_arbiter_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

  localparam logic [WAIT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic              aux_ack_q, aux_ack_d;
  logic [15:0]       aux_rdata_q, aux_rdata_d;
  logic [WAIT_W-1:0] grant_cnt_q, grant_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [WAIT_W-1:0] wait_max_q, wait_max_d;

  logic        cpu_rd;
  logic        cpu_wr;
  logic        cpu_act;
  logic        cpu_stat;
  logic        aux_stat;
  logic        grant;
  logic [15:0] status;

  // RAM writes (below 0x4000) are not bus activity and never block the aux master
  assign cpu_rd   = bus.io_rd;
  assign cpu_wr   = bus.io_wr & (bus.io_addr[15:14] != 2'b00);
  assign cpu_act  = cpu_rd | cpu_wr;
  assign cpu_stat = (bus.io_addr == STAT_ADDR);
  assign aux_stat = (bus.aux_addr == STAT_ADDR);
  assign grant    = (state_q == ST_IDLE) & bus.aux_req & ~cpu_act;
  assign status   = 16'({wait_max_q, grant_cnt_q});

  // Combinational read-data mux back to the CPU
  assign bus.io_din = sys_rst_i ? 16'h0000 : (cpu_stat ? status : bus.per_rdata);

  // Peripheral bus drive: CPU first, then a same-cycle aux grant
  always_comb begin
    bus.per_cs    = 1'b0;
    bus.per_we    = 1'b0;
    bus.per_addr  = 16'h0000;
    bus.per_wdata = 16'h0000;
    if (!sys_rst_i) begin
      if (cpu_act) begin
        if (!cpu_stat) begin
          bus.per_cs    = 1'b1;
          bus.per_we    = cpu_wr;
          bus.per_addr  = bus.io_addr;
          bus.per_wdata = bus.io_dout;
        end
      end else if (grant && !aux_stat) begin
        bus.per_cs    = 1'b1;
        bus.per_we    = bus.aux_we;
        bus.per_addr  = bus.aux_addr;
        bus.per_wdata = bus.aux_wdata;
      end
    end
  end

  // Next-state: grant/ack sequencing, aux read capture and statistics counters
  always_comb begin
    state_d     = ST_IDLE;
    aux_ack_d   = 1'b0;
    aux_rdata_d = aux_rdata_q;
    grant_cnt_d = grant_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    wait_max_d  = wait_max_q;
    if (grant) begin
      state_d     = ST_ACK;
      aux_ack_d   = 1'b1;
      aux_rdata_d = bus.aux_we ? 16'h0000 : (aux_stat ? status : bus.per_rdata);
      grant_cnt_d = grant_cnt_q + WAIT_W'(1);
      wait_cnt_d  = '0;
      if (wait_cnt_q > wait_max_q) begin
        wait_max_d = wait_cnt_q;
      end
    end else if ((state_q == ST_IDLE) && bus.aux_req && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
    // Status clear by the CPU overrides any same-cycle counter update
    if (cpu_wr && cpu_stat) begin
      grant_cnt_d = '0;
      wait_max_d  = '0;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q     <= ST_IDLE;
      aux_ack_q   <= 1'b0;
      aux_rdata_q <= 16'h0000;
      grant_cnt_q <= '0;
      wait_cnt_q  <= '0;
      wait_max_q  <= '0;
    end else begin
      state_q     <= state_d;
      aux_ack_q   <= aux_ack_d;
      aux_rdata_q <= aux_rdata_d;
      grant_cnt_q <= grant_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      wait_max_q  <= wait_max_d;
    end
  end

  assign bus.aux_ack   = aux_ack_q;
  assign bus.aux_rdata = aux_rdata_q;

endmodule
